// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared types and defaults for the FIR control block:
//               FSM state encoding, timing/bank defaults, address widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   localparam int c_SAMPLE_DIV    = 20;   // 12 MHz clocks per 600 kHz sample
   localparam int c_TAPS_PER_BANK = 10;   // coefficient taps per MAC bank
   localparam int c_NUM_BANKS     = 4;    // MAC banks feeding the summer
   localparam int c_COEF_ADDR_W   = 6;    // flat coefficient address width
   localparam int c_BANK_ADDR_W   = 4;    // bank-local / tap address width
   localparam int c_COEF_W        = 16;   // coefficient data width

endpackage
`default_nettype wire

// File: rtl/fir_sample_timer.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_timer
// Description : Sample-period divider and MAC tap sequencer. Counts one
//               sample period while RUN and issues registered accumulator
//               clear, MAC enable/tap address, sample strobe and
//               delay-line valid.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_timer
   import fir_pkg::*;
#(
   parameter int SAMPLE_DIV    = c_SAMPLE_DIV,
   parameter int TAPS_PER_BANK = c_TAPS_PER_BANK
) (
   input  logic                     iClk_12M,
   input  logic                     iRst,
   input  logic                     iRun,
   output logic                     oDivLast,
   output logic [c_BANK_ADDR_W-1:0] oRdAddr,
   output logic                     oEnMac,
   output logic                     oClrAcc,
   output logic                     oEnSample_600k,
   output logic                     oEnDelay
);

   localparam int                 c_DIV_W    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SAMPLE_DIV - 1);
   localparam logic [c_DIV_W-1:0] c_TAPS     = c_DIV_W'(TAPS_PER_BANK);

   logic [c_DIV_W-1:0] r_div;
   logic               w_tapWin;

   // Last cycle of the sample period; the FSM uses it to let a sample finish
   assign oDivLast = iRun && (r_div == c_DIV_LAST);
   assign w_tapWin = iRun && (r_div < c_TAPS);

   // Divider: cycles through one sample period in RUN, parked at 0 otherwise
   always_ff @(posedge iClk_12M or posedge iRst) begin
      if (iRst) begin
         r_div <= '0;
      end else if (!iRun || (r_div == c_DIV_LAST)) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // Sequencing outputs, registered one cycle behind the divider value
   always_ff @(posedge iClk_12M or posedge iRst) begin
      if (iRst) begin
         oClrAcc        <= 1'b0;
         oEnMac         <= 1'b0;
         oRdAddr        <= '0;
         oEnSample_600k <= 1'b0;
         oEnDelay       <= 1'b0;
      end else begin
         oClrAcc        <= iRun && (r_div == '0);
         oEnMac         <= w_tapWin;
         oRdAddr        <= w_tapWin ? c_BANK_ADDR_W'(r_div) : '0;
         oEnSample_600k <= oDivLast;
         // delay line holds valid data once a full sample has been strobed
         if (!iRun) begin
            oEnDelay <= 1'b0;
         end else if (oEnSample_600k) begin
            oEnDelay <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_ctrl
// Description : FIR controller top. IDLE/UPDATE/RUN mode FSM, coefficient
//               write decode into per-bank RAM strobes, and the sample
//               timer instance.
//               Optional macro FIR_CTRL_ERR_EN adds a sticky oErr output
//               flagging rejected coefficient writes.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_ctrl
   import fir_pkg::*;
#(
   parameter int SAMPLE_DIV    = c_SAMPLE_DIV,
   parameter int TAPS_PER_BANK = c_TAPS_PER_BANK,
   parameter int NUM_BANKS     = c_NUM_BANKS
) (
   input  logic                        iClk_12M,
   input  logic                        iRst,
   input  logic                        iCoeffUpdateFlag,
   input  logic                        iCsnRam,
   input  logic                        iWrRam,
   input  logic [c_COEF_ADDR_W-1:0]    iAddrRam,
   input  logic signed [c_COEF_W-1:0]  iWrDtRam,
   output logic [NUM_BANKS-1:0]        oCsnRam,
   output logic [NUM_BANKS-1:0]        oWrRam,
   output logic [c_BANK_ADDR_W-1:0]    oAddrRam,
   output logic [c_COEF_W-1:0]         oWrDtRam,
   output logic [c_BANK_ADDR_W-1:0]    oRdAddr,
   output logic                        oEnMac,
   output logic                        oClrAcc,
   output logic                        oEnSample_600k,
   output logic                        oEnDelay,
   output logic [1:0]                  oState
`ifdef FIR_CTRL_ERR_EN
   ,
   output logic                        oErr
`endif
);

   localparam logic [c_COEF_ADDR_W:0]   c_NUM_COEF = (c_COEF_ADDR_W+1)'(NUM_BANKS * TAPS_PER_BANK);
   localparam logic [c_COEF_ADDR_W-1:0] c_TAPS     = c_COEF_ADDR_W'(TAPS_PER_BANK);

   state_t                   r_state;
   logic                     w_run;
   logic                     w_divLast;
   logic                     w_goUpdate;
   logic                     w_wrAttempt;
   logic                     w_wrAccept;
   logic [c_COEF_ADDR_W-1:0] w_bank;
   logic [c_COEF_ADDR_W-1:0] w_bankAddr;

   assign w_run       = (r_state == ST_RUN);
   // RUN only yields to UPDATE on the last divider count so the sample completes
   assign w_goUpdate  = iCoeffUpdateFlag && ((r_state != ST_RUN) || w_divLast);
   assign w_wrAttempt = !iCsnRam && iWrRam;
   // state is judged before the transition, so a write on the UPDATE exit edge lands
   assign w_wrAccept  = w_wrAttempt && (r_state == ST_UPDATE) && ({1'b0, iAddrRam} < c_NUM_COEF);
   assign w_bank      = iAddrRam / c_TAPS;
   assign w_bankAddr  = iAddrRam % c_TAPS;
   assign oState      = r_state;

   // Mode FSM
   always_ff @(posedge iClk_12M or posedge iRst) begin
      if (iRst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   r_state <= iCoeffUpdateFlag ? ST_UPDATE : ST_RUN;
            ST_UPDATE: r_state <= iCoeffUpdateFlag ? ST_UPDATE : ST_RUN;
            ST_RUN:    r_state <= w_goUpdate ? ST_UPDATE : ST_RUN;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   // Coefficient write decode: flat address -> one-cold bank select plus local address
   always_ff @(posedge iClk_12M or posedge iRst) begin
      if (iRst) begin
         oCsnRam  <= '1;
         oWrRam   <= '0;
         oAddrRam <= '0;
         oWrDtRam <= '0;
      end else if (w_wrAccept) begin
         oCsnRam  <= ~(NUM_BANKS'(1) << w_bank);
         oWrRam   <= NUM_BANKS'(1) << w_bank;
         oAddrRam <= c_BANK_ADDR_W'(w_bankAddr);
         oWrDtRam <= iWrDtRam;
      end else begin
         oCsnRam  <= '1;
         oWrRam   <= '0;
      end
   end

`ifdef FIR_CTRL_ERR_EN
   // Sticky rejected-write flag, cleared each time a new update session starts
   always_ff @(posedge iClk_12M or posedge iRst) begin
      if (iRst) begin
         oErr <= 1'b0;
      end else if (w_goUpdate && (r_state != ST_UPDATE)) begin
         oErr <= 1'b0;
      end else if (w_wrAttempt && !w_wrAccept) begin
         oErr <= 1'b1;
      end
   end
`endif

   fir_sample_timer #(
      .SAMPLE_DIV    (SAMPLE_DIV),
      .TAPS_PER_BANK (TAPS_PER_BANK)
   ) u_timer (
      .iClk_12M       (iClk_12M),
      .iRst           (iRst),
      .iRun           (w_run),
      .oDivLast       (w_divLast),
      .oRdAddr        (oRdAddr),
      .oEnMac         (oEnMac),
      .oClrAcc        (oClrAcc),
      .oEnSample_600k (oEnSample_600k),
      .oEnDelay       (oEnDelay)
   );

endmodule
`default_nettype wire

// File: tb/tb_fir_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fir_ctrl
// Description : Self-checking bench for fir_ctrl with a behavioural model
//               (sample phase counter + write address arithmetic).
//               Honours FIR_CTRL_ERR_EN for the oErr output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_ctrl;

   localparam int SDIV = 20;
   localparam int TAPS = 10;
   localparam int NB   = 4;

   logic        iClk_12M = 1'b0;
   logic        iRst;
   logic        iCoeffUpdateFlag;
   logic        iCsnRam;
   logic        iWrRam;
   logic [5:0]  iAddrRam;
   logic [15:0] iWrDtRam;
   logic [3:0]  oCsnRam;
   logic [3:0]  oWrRam;
   logic [3:0]  oAddrRam;
   logic [15:0] oWrDtRam;
   logic [3:0]  oRdAddr;
   logic        oEnMac;
   logic        oClrAcc;
   logic        oEnSample_600k;
   logic        oEnDelay;
   logic [1:0]  oState;
`ifdef FIR_CTRL_ERR_EN
   logic        oErr;
`endif

   int errors = 0;
   int checks = 0;

   always #5 iClk_12M = ~iClk_12M;

   fir_ctrl dut (
      .iClk_12M         (iClk_12M),
      .iRst             (iRst),
      .iCoeffUpdateFlag (iCoeffUpdateFlag),
      .iCsnRam          (iCsnRam),
      .iWrRam           (iWrRam),
      .iAddrRam         (iAddrRam),
      .iWrDtRam         (iWrDtRam),
      .oCsnRam          (oCsnRam),
      .oWrRam           (oWrRam),
      .oAddrRam         (oAddrRam),
      .oWrDtRam         (oWrDtRam),
      .oRdAddr          (oRdAddr),
      .oEnMac           (oEnMac),
      .oClrAcc          (oClrAcc),
      .oEnSample_600k   (oEnSample_600k),
      .oEnDelay         (oEnDelay),
      .oState           (oState)
`ifdef FIR_CTRL_ERR_EN
      ,
      .oErr             (oErr)
`endif
   );

   // ---------------- behavioural model ----------------
   // mPh = position inside the current sample period (-1 when not running)
   int          mState;
   int          mPh;
   logic        mClr, mMac, mSmp, mDly, mErr;
   logic [3:0]  mRd, mCsn, mWr, mAddr;
   logic [15:0] mDt;

   task automatic mdlReset();
      mState = 0; mPh = -1;
      mClr = 0; mMac = 0; mSmp = 0; mDly = 0; mErr = 0;
      mRd = 0; mCsn = 4'hF; mWr = 0; mAddr = 0; mDt = 0;
   endtask

   task automatic mdlEdge();
      bit run, att, acc;
      int nxt, bank;
      run  = (mState == 2);
      att  = !iCsnRam && iWrRam;
      acc  = att && (mState == 1) && (int'(iAddrRam) < NB * TAPS);
      bank = int'(iAddrRam) / TAPS;
      mDly = run && (mDly || mSmp);
      mClr = run && (mPh == 0);
      mMac = run && (mPh < TAPS);
      mRd  = (run && mPh < TAPS) ? 4'(mPh) : 4'd0;
      mSmp = run && (mPh == SDIV - 1);
      if (acc) begin
         mCsn  = 4'hF ^ (4'd1 << bank);
         mWr   = 4'd1 << bank;
         mAddr = 4'(int'(iAddrRam) % TAPS);
         mDt   = iWrDtRam;
      end else begin
         mCsn = 4'hF;
         mWr  = 4'd0;
      end
      if (mState == 2) nxt = (iCoeffUpdateFlag && mPh == SDIV - 1) ? 1 : 2;
      else             nxt = iCoeffUpdateFlag ? 1 : 2;
      if (nxt == 1 && mState != 1) mErr = 0;
      else if (att && !acc)        mErr = 1;
      mPh    = (nxt != 2) ? -1 : (run ? (mPh + 1) % SDIV : 0);
      mState = nxt;
   endtask

   function automatic logic [37:0] dutVec();
      return {oState, oCsnRam, oWrRam, oAddrRam, oWrDtRam, oRdAddr,
              oEnMac, oClrAcc, oEnSample_600k, oEnDelay};
   endfunction

   function automatic logic [37:0] mdlVec();
      return {2'(mState), mCsn, mWr, mAddr, mDt, mRd, mMac, mClr, mSmp, mDly};
   endfunction

   localparam logic [37:0] RESET_VEC = {2'd0, 4'hF, 4'h0, 4'h0, 16'h0, 4'h0, 4'b0000};

   task automatic step();
      @(posedge iClk_12M);
      mdlEdge();
      #1;
   endtask

   task automatic wrIdle();
      iCsnRam = 1'b1; iWrRam = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      iRst = 1'b1; iCoeffUpdateFlag = 1'b0; wrIdle();
      iAddrRam = 0; iWrDtRam = 0;
      repeat (3) @(posedge iClk_12M);
      #1;
      mdlReset();
      checks++;
      if (dutVec() !== RESET_VEC) begin
         errors++; $display("FAIL reset_vec: got %h expected %h", dutVec(), RESET_VEC);
      end
`ifdef FIR_CTRL_ERR_EN
      checks++;
      if (oErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", oErr); end
`endif
      iRst = 1'b0;
      #2;
      checks++;
      if (oState !== 2'd0) begin errors++; $display("FAIL release_idle: got %0d expected 0", oState); end
      step();
      checks++;
      if (oState !== 2'd2) begin errors++; $display("FAIL enter_run: got %0d expected 2", oState); end
   endtask

   task automatic test_run_timing();
      int  firstSmp, nSmp, nMac, nClr;
      bit  seqOk;
      firstSmp = 0; nSmp = 0; nMac = 0; nClr = 0; seqOk = 1;
      for (int cyc = 2; cyc <= 61; cyc++) begin
         step();
         checks++;
         if (dutVec() !== mdlVec()) begin
            errors++; $display("FAIL run_vec cyc%0d: got %h expected %h", cyc, dutVec(), mdlVec());
         end
         if (oEnSample_600k === 1'b1) begin
            nSmp++;
            if (firstSmp == 0) firstSmp = cyc;
            checks++;
            if (((cyc - 21) % SDIV) != 0) begin
               errors++; $display("FAIL smp_period: got cycle %0d expected 21+20n", cyc);
            end
         end
         if (cyc <= 21) begin
            if (oEnMac === 1'b1) begin
               nMac++;
               if (oRdAddr !== 4'(cyc - 2)) seqOk = 0;
            end
            if (oClrAcc === 1'b1) nClr++;
         end
         if (cyc == 21) begin
            checks++;
            if (oEnDelay !== 1'b0) begin errors++; $display("FAIL delay_early: got %b expected 0", oEnDelay); end
         end
         if (cyc == 22) begin
            checks++;
            if (oEnDelay !== 1'b1) begin errors++; $display("FAIL delay_set: got %b expected 1", oEnDelay); end
         end
      end
      checks++;
      if (firstSmp != 21) begin errors++; $display("FAIL first_smp: got %0d expected 21", firstSmp); end
      checks++;
      if (nSmp != 3) begin errors++; $display("FAIL smp_count: got %0d expected 3", nSmp); end
      checks++;
      if (nMac != TAPS) begin errors++; $display("FAIL mac_count: got %0d expected %0d", nMac, TAPS); end
      checks++;
      if (nClr != 1) begin errors++; $display("FAIL clr_count: got %0d expected 1", nClr); end
      checks++;
      if (!seqOk) begin errors++; $display("FAIL rd_seq: got out-of-order expected 0..9"); end
   endtask

   task automatic test_flag_mid_sample();
      int k;
      for (int i = 0; i < 25 && mPh != 3; i++) step();
      checks++;
      if (mPh != 3) begin errors++; $display("FAIL reach_div3: got %0d expected 3", mPh); end
      iCoeffUpdateFlag = 1'b1;
      k = 0;
      while (oState !== 2'd1 && k < 30) begin
         step(); k++;
         checks++;
         if (dutVec() !== mdlVec()) begin
            errors++; $display("FAIL mid_vec k%0d: got %h expected %h", k, dutVec(), mdlVec());
         end
      end
      checks++;
      if (k != 17) begin errors++; $display("FAIL update_latency: got %0d expected 17", k); end
      checks++;
      if (oEnSample_600k !== 1'b1) begin errors++; $display("FAIL final_smp: got %b expected 1", oEnSample_600k); end
      step();
      checks++;
      if (oEnDelay !== 1'b0 || oEnSample_600k !== 1'b0) begin
         errors++; $display("FAIL leave_run: got dly=%b smp=%b expected 0 0", oEnDelay, oEnSample_600k);
      end
   endtask

   task automatic test_update_write();
      iCsnRam = 1'b0; iWrRam = 1'b1; iAddrRam = 6'd25; iWrDtRam = 16'h8001;
      step(); wrIdle();
      checks++;
      if ({oCsnRam, oWrRam, oAddrRam, oWrDtRam} !== {4'b1011, 4'b0100, 4'd5, 16'h8001}) begin
         errors++; $display("FAIL wr25: got %b %b %0d %h expected 1011 0100 5 8001",
                            oCsnRam, oWrRam, oAddrRam, oWrDtRam);
      end
      iCsnRam = 1'b0; iWrRam = 1'b1; iAddrRam = 6'd40; iWrDtRam = 16'h1234;
      step(); wrIdle();
      checks++;
      if (oCsnRam !== 4'hF || oWrRam !== 4'h0) begin
         errors++; $display("FAIL wr40: got csn=%b wr=%b expected 1111 0000", oCsnRam, oWrRam);
      end
`ifdef FIR_CTRL_ERR_EN
      checks++;
      if (oErr !== 1'b1) begin errors++; $display("FAIL err40: got %b expected 1", oErr); end
`endif
      for (int i = 0; i < 40; i++) begin
         iCsnRam  = ($urandom_range(0, 3) == 0);
         iWrRam   = ($urandom_range(0, 3) != 0);
         iAddrRam = 6'($urandom_range(0, 47));
         iWrDtRam = 16'($urandom);
         step();
         checks++;
         if (dutVec() !== mdlVec()) begin
            errors++; $display("FAIL upd_rand%0d: got %h expected %h", i, dutVec(), mdlVec());
         end
`ifdef FIR_CTRL_ERR_EN
         checks++;
         if (oErr !== mErr) begin errors++; $display("FAIL upd_err%0d: got %b expected %b", i, oErr, mErr); end
`endif
      end
      wrIdle();
      step();
   endtask

   task automatic test_exit_write();
      iCoeffUpdateFlag = 1'b0;
      iCsnRam = 1'b0; iWrRam = 1'b1; iAddrRam = 6'd7; iWrDtRam = 16'h00A5;
      step(); wrIdle();
      checks++;
      if ({oState, oCsnRam, oWrRam, oAddrRam, oWrDtRam} !== {2'd2, 4'b1110, 4'b0001, 4'd7, 16'h00A5}) begin
         errors++; $display("FAIL exit_write: got st=%0d csn=%b wr=%b a=%0d d=%h expected 2 1110 0001 7 00a5",
                            oState, oCsnRam, oWrRam, oAddrRam, oWrDtRam);
      end
   endtask

   task automatic test_run_write();
      int k;
      iCsnRam = 1'b0; iWrRam = 1'b1; iAddrRam = 6'd3; iWrDtRam = 16'h5555;
      step(); wrIdle();
      checks++;
      if (oCsnRam !== 4'hF || oWrRam !== 4'h0) begin
         errors++; $display("FAIL run_write: got csn=%b wr=%b expected 1111 0000", oCsnRam, oWrRam);
      end
`ifdef FIR_CTRL_ERR_EN
      checks++;
      if (oErr !== 1'b1) begin errors++; $display("FAIL run_err: got %b expected 1", oErr); end
`endif
      iCoeffUpdateFlag = 1'b1;
      k = 0;
      while (oState !== 2'd1 && k < 30) begin
         step(); k++;
         checks++;
         if (dutVec() !== mdlVec()) begin
            errors++; $display("FAIL rw_vec k%0d: got %h expected %h", k, dutVec(), mdlVec());
         end
`ifdef FIR_CTRL_ERR_EN
         checks++;
         if (oErr !== mErr) begin errors++; $display("FAIL rw_err k%0d: got %b expected %b", k, oErr, mErr); end
`endif
      end
      checks++;
      if (oState !== 2'd1) begin errors++; $display("FAIL rw_update: got %0d expected 1", oState); end
`ifdef FIR_CTRL_ERR_EN
      checks++;
      if (oErr !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", oErr); end
`endif
      iCoeffUpdateFlag = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      int nSmp;
      for (int i = 0; i < 25 && mPh != 5; i++) step();
      checks++;
      if (mPh != 5) begin errors++; $display("FAIL reach_div5: got %0d expected 5", mPh); end
      #2;
      iRst = 1'b1;
      #1;
      mdlReset();
      checks++;
      if (dutVec() !== RESET_VEC) begin
         errors++; $display("FAIL async_reset: got %h expected %h", dutVec(), RESET_VEC);
      end
`ifdef FIR_CTRL_ERR_EN
      checks++;
      if (oErr !== 1'b0) begin errors++; $display("FAIL async_err: got %b expected 0", oErr); end
`endif
      nSmp = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge iClk_12M);
         if (oEnSample_600k !== 1'b0 || oState !== 2'd0) nSmp++;
      end
      checks++;
      if (nSmp != 0) begin errors++; $display("FAIL reset_hold: got %0d active cycles expected 0", nSmp); end
      iRst = 1'b0;
      step();
      checks++;
      if (oState !== 2'd2) begin errors++; $display("FAIL resume_run: got %0d expected 2", oState); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) iCoeffUpdateFlag = ~iCoeffUpdateFlag;
         iCsnRam  = ($urandom_range(0, 2) == 0);
         iWrRam   = ($urandom_range(0, 2) != 0);
         iAddrRam = 6'($urandom_range(0, 47));
         iWrDtRam = 16'($urandom);
         step();
         checks++;
         if (dutVec() !== mdlVec()) begin
            errors++; $display("FAIL rand%0d: got %h expected %h", i, dutVec(), mdlVec());
         end
`ifdef FIR_CTRL_ERR_EN
         checks++;
         if (oErr !== mErr) begin errors++; $display("FAIL rand_err%0d: got %b expected %b", i, oErr, mErr); end
`endif
      end
      wrIdle();
   endtask

   initial begin
      test_reset();
      test_run_timing();
      test_flag_mid_sample();
      test_update_write();
      test_exit_write();
      test_run_write();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
